c_fetch_ctrl: RTL



---
 rtl/c_fetch_pkg.sv | 16 +
 rtl/c_fetch_align.sv | 46 ++++
 rtl/c_fetch_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/c_fetch_pkg.sv
// Shared state encoding and helpers for the RV32IC fetch sequencer.
package c_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic is_c(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/c_fetch_align.sv
// Combinational realignment of one fetched word against the leftover halfword.
// Produces the instruction to emit (if any) and the new halfword buffer contents.
module c_fetch_align
  import c_fetch_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_hw_buf,
  input  logic        i_hw_valid,
  input  logic        i_fpc1,
  output logic        o_emit,
  output logic [31:0] o_inst,
  output logic        o_is_c,
  output logic [15:0] o_hw_buf,
  output logic        o_hw_valid
);

  logic w_lo_c;
  logic w_hi_c;

  assign w_lo_c = is_c(i_rdata[15:0]);
  assign w_hi_c = is_c(i_rdata[31:16]);

  always_comb begin
    o_emit     = 1'b1;
    o_inst     = i_rdata;
    o_is_c     = 1'b0;
    o_hw_buf   = i_rdata[31:16];
    o_hw_valid = 1'b0;
    if (i_hw_valid) begin
      // Buffered low half of a 32-bit instruction; the new upper half stays buffered.
      o_inst     = {i_rdata[15:0], i_hw_buf};
      o_hw_valid = 1'b1;
    end else if (i_fpc1) begin
      // Odd target: only the upper halfword belongs to the stream.
      o_emit     = w_hi_c;
      o_is_c     = w_hi_c;
      o_inst     = {16'h0000, i_rdata[31:16]};
      o_hw_valid = !w_hi_c;
    end else if (w_lo_c) begin
      o_is_c     = 1'b1;
      o_inst     = {16'h0000, i_rdata[15:0]};
      o_hw_valid = 1'b1;
    end
  end

endmodule

// File: rtl/c_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues word requests, emits one whole
// 16/32-bit instruction per decode handshake without realignment bubbles.
module c_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_is_c_o
);

  import c_fetch_pkg::*;

  state_t      r_state, w_state;
  logic [31:0] r_fpc, w_fpc;
  logic [31:0] r_faddr, w_faddr;
  logic [15:0] r_hw_buf, w_hw_buf;
  logic        r_hw_valid, w_hw_valid;
  logic        r_drop, w_drop;
  logic        r_req, w_req;
  logic        r_inst_valid, w_inst_valid;
  logic [31:0] r_inst, w_inst;
  logic [31:0] r_inst_pc, w_inst_pc;
  logic        r_inst_is_c, w_inst_is_c;

  logic        w_fire;
  logic        w_accept;
  logic        w_al_emit;
  logic [31:0] w_al_inst;
  logic        w_al_is_c;
  logic [15:0] w_al_hw_buf;
  logic        w_al_hw_valid;

  assign w_fire   = r_req & imem_gnt_i;
  assign w_accept = r_inst_valid & inst_ready_i;

  c_fetch_align u_align (
    .i_rdata    (imem_rdata_i),
    .i_hw_buf   (r_hw_buf),
    .i_hw_valid (r_hw_valid),
    .i_fpc1     (r_fpc[1]),
    .o_emit     (w_al_emit),
    .o_inst     (w_al_inst),
    .o_is_c     (w_al_is_c),
    .o_hw_buf   (w_al_hw_buf),
    .o_hw_valid (w_al_hw_valid)
  );

  always_comb begin
    w_state      = r_state;
    w_fpc        = r_fpc;
    w_faddr      = r_faddr;
    w_hw_buf     = r_hw_buf;
    w_hw_valid   = r_hw_valid;
    w_drop       = r_drop;
    w_inst_valid = 1'b0;
    w_inst       = NOP_INST;
    w_inst_pc    = r_inst_pc;
    w_inst_is_c  = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (w_fire) begin
          w_state = S_WAIT;
          w_faddr = r_faddr + 32'd4;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (r_drop) begin
            w_drop  = 1'b0;
            w_state = S_FETCH;
          end else begin
            w_hw_buf   = w_al_hw_buf;
            w_hw_valid = w_al_hw_valid;
            if (w_al_emit) begin
              w_state      = S_OUT;
              w_inst_valid = 1'b1;
              w_inst       = w_al_inst;
              w_inst_is_c  = w_al_is_c;
              w_inst_pc    = r_fpc;
            end else begin
              w_state = S_FETCH;
            end
          end
        end
      end
      S_OUT: begin
        if (!w_accept) begin
          w_inst_valid = 1'b1;
          w_inst       = r_inst;
          w_inst_is_c  = r_inst_is_c;
        end else begin
          w_fpc = r_fpc + (r_inst_is_c ? 32'd2 : 32'd4);
          // A compressed leftover goes out next cycle without touching memory.
          if (r_hw_valid && is_c(r_hw_buf)) begin
            w_inst_valid = 1'b1;
            w_inst       = {16'h0000, r_hw_buf};
            w_inst_is_c  = 1'b1;
            w_inst_pc    = w_fpc;
            w_hw_valid   = 1'b0;
          end else begin
            w_state = S_FETCH;
          end
        end
      end
      default: w_state = S_FETCH;
    endcase

    if (redirect_i) begin
      w_fpc        = redirect_pc_i & 32'hFFFF_FFFE;
      w_faddr      = redirect_pc_i & 32'hFFFF_FFFC;
      w_hw_valid   = 1'b0;
      w_inst_valid = 1'b0;
      w_inst       = NOP_INST;
      w_inst_is_c  = 1'b0;
      // A response still in flight must be swallowed before refetching; one
      // arriving this very cycle is already consumed, so nothing is left to drop.
      if ((r_state == S_WAIT && !imem_rvalid_i) || (r_state == S_FETCH && w_fire)) begin
        w_drop  = 1'b1;
        w_state = S_WAIT;
      end else begin
        w_drop  = 1'b0;
        w_state = S_FETCH;
      end
    end

    w_req = (w_state == S_FETCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_fpc        <= RESET_PC & 32'hFFFF_FFFE;
      r_faddr      <= RESET_PC & 32'hFFFF_FFFC;
      r_hw_buf     <= 16'h0000;
      r_hw_valid   <= 1'b0;
      r_drop       <= 1'b0;
      r_req        <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= RESET_PC;
      r_inst_is_c  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_fpc        <= w_fpc;
      r_faddr      <= w_faddr;
      r_hw_buf     <= w_hw_buf;
      r_hw_valid   <= w_hw_valid;
      r_drop       <= w_drop;
      r_req        <= w_req;
      r_inst_valid <= w_inst_valid;
      r_inst       <= w_inst;
      r_inst_pc    <= w_inst_pc;
      r_inst_is_c  <= w_inst_is_c;
    end
  end

  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_faddr;
  assign inst_valid_o = r_inst_valid;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign inst_is_c_o  = r_inst_is_c;

endmodule
